// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - Branch condition resolver with 2-bit BHT predictor and mispredict counter
module branch_predict_resolve #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_out_vld,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [2:0]        Branch_type,
    input  logic              res_pred,
    output logic              res_out_vld,
    output logic              res_taken,
    output logic              mispredict,
    output logic [CNT_W-1:0]  mispred_cnt,
    input  logic              cnt_clr
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             cond_taken;
    logic             mispred_d;
    logic             upd_en;
    logic [1:0]       upd_old;
    logic [1:0]       upd_val;
    logic             rs_neg;
    logic             rs_zero;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                              res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

    assign rs_neg  = rs_data[DATA_W-1];
    assign rs_zero = (rs_data == '0);

    always_comb begin
        cond_taken = 1'b0;
        case (Branch_type)
            3'b001:  cond_taken = (rs_data == rt_data);
            3'b010:  cond_taken = (rs_data != rt_data);
            3'b011:  cond_taken = rs_neg;
            3'b100:  cond_taken = rs_neg | rs_zero;
            3'b101:  cond_taken = ~rs_neg & ~rs_zero;
            3'b110:  cond_taken = ~rs_neg;
            default: cond_taken = 1'b0;
        endcase
    end

    assign mispred_d = res_valid & (cond_taken != res_pred);
    assign upd_en    = res_valid & (Branch_type != 3'b000) & (Branch_type != 3'b111);
    assign upd_old   = bht[res_idx];

    // Saturating 2-bit counter step
    always_comb begin
        upd_val = upd_old;
        if (cond_taken) begin
            if (upd_old != 2'b11) upd_val = upd_old + 2'd1;
        end else begin
            if (upd_old != 2'b00) upd_val = upd_old - 2'd1;
        end
    end

    // Lookup reads bht before this edge's update lands, giving pre-update value on same-index collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (upd_en) begin
            bht[res_idx] <= upd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_out_vld <= 1'b0;
            pred_taken   <= 1'b0;
            res_out_vld  <= 1'b0;
            res_taken    <= 1'b0;
            mispredict   <= 1'b0;
        end else begin
            pred_out_vld <= pred_valid;
            pred_taken   <= pred_valid & bht[pred_idx][1];
            res_out_vld  <= res_valid;
            res_taken    <= res_valid & cond_taken;
            mispredict   <= mispred_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (cnt_clr) begin
            mispred_cnt <= '0;
        end else if (mispred_d && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - Self-checking bench for branch_predict_resolve
module tb_branch_predict_resolve;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [2:0]  Branch_type = '0;
    logic        res_pred = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        pred_out_vld, pred_taken, res_out_vld, res_taken, mispredict;
    logic [15:0] mispred_cnt;
    logic        pred_out_vld2, pred_taken2, res_out_vld2, res_taken2, mispredict2;
    logic [1:0]  mispred_cnt2;

    int total = 0;
    int passed = 0;

    branch_predict_resolve dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_vld(pred_out_vld), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc),
        .rs_data(rs_data), .rt_data(rt_data),
        .Branch_type(Branch_type), .res_pred(res_pred),
        .res_out_vld(res_out_vld), .res_taken(res_taken),
        .mispredict(mispredict), .mispred_cnt(mispred_cnt),
        .cnt_clr(cnt_clr)
    );

    branch_predict_resolve #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_vld(pred_out_vld2), .pred_taken(pred_taken2),
        .res_valid(res_valid), .res_pc(res_pc),
        .rs_data(rs_data), .rt_data(rt_data),
        .Branch_type(Branch_type), .res_pred(res_pred),
        .res_out_vld(res_out_vld2), .res_taken(res_taken2),
        .mispredict(mispredict2), .mispred_cnt(mispred_cnt2),
        .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: counters held as plain integers 0..3
    int m_bht [64];
    int m_cnt, m_cnt2;
    bit e_pv, e_pt, e_rv, e_rt, e_mp;

    function automatic bit cond(input logic [31:0] rs, input logic [31:0] rt, input logic [2:0] bt);
        case (bt)
            3'd1:    return rs == rt;
            3'd2:    return rs != rt;
            3'd3:    return $signed(rs) < 0;
            3'd4:    return $signed(rs) <= 0;
            3'd5:    return $signed(rs) > 0;
            3'd6:    return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_cnt = 0; m_cnt2 = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 64; i++) m_bht[i] = 1;
                m_cnt = 0; m_cnt2 = 0;
                e_pv = 0; e_pt = 0; e_rv = 0; e_rt = 0; e_mp = 0;
            end else begin
                bit t;
                t = cond(rs_data, rt_data, Branch_type);
                e_pv = pred_valid;
                e_pt = pred_valid && (m_bht[idx_of(pred_pc)] >= 2);
                e_rv = res_valid;
                e_rt = res_valid && t;
                e_mp = res_valid && (t != res_pred);
                if (cnt_clr) begin
                    m_cnt = 0; m_cnt2 = 0;
                end else if (e_mp) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
                if (res_valid && Branch_type >= 3'd1 && Branch_type <= 3'd6) begin
                    int k;
                    k = idx_of(res_pc);
                    if (t) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
                    else   m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("pred_out_vld", {31'd0, pred_out_vld}, {31'd0, e_pv});
            chk("pred_taken",   {31'd0, pred_taken},   {31'd0, e_pt});
            chk("res_out_vld",  {31'd0, res_out_vld},  {31'd0, e_rv});
            chk("res_taken",    {31'd0, res_taken},    {31'd0, e_rt});
            chk("mispredict",   {31'd0, mispredict},   {31'd0, e_mp});
            chk("mispred_cnt",  {16'd0, mispred_cnt},  m_cnt);
            chk("mispred_cnt2", {30'd0, mispred_cnt2}, m_cnt2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        pred_valid = 0; res_valid = 0; cnt_clr = 0;
    endtask

    task automatic res(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [2:0] bt, input logic pr);
        res_valid = 1; res_pc = pc; rs_data = rs; rt_data = rt; Branch_type = bt; res_pred = pr;
    endtask

    task automatic lookup(input logic [31:0] pc);
        pred_valid = 1; pred_pc = pc;
    endtask

    logic [31:0] c_rs [8] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'd0, 32'd0, 32'd0, 32'd0};
    logic [2:0]  c_bt [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd3, 3'd4, 3'd5, 3'd6};
    logic        c_ex [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        repeat (2) cyc();
        chk("reset_res_out_vld", {31'd0, res_out_vld}, 0);
        chk("reset_cnt", {16'd0, mispred_cnt}, 0);
        rst_n = 1;

        lookup(32'h40); cyc(); idle();
        chk("post_reset_lookup_vld", {31'd0, pred_out_vld}, 1);
        chk("post_reset_lookup_taken", {31'd0, pred_taken}, 0);

        for (int i = 0; i < 8; i++) begin
            res(32'h100, c_rs[i], 32'd0, c_bt[i], 1'b0); cyc();
            chk($sformatf("cond_%0d", i), {31'd0, res_taken}, {31'd0, c_ex[i]});
        end
        res(32'h100, 32'd5, 32'd5, 3'd1, 1'b0); cyc();
        chk("beq_equal", {31'd0, res_taken}, 1);
        res(32'h100, 32'd5, 32'd5, 3'd2, 1'b0); cyc();
        chk("bne_equal", {31'd0, res_taken}, 0);

        // Saturate idx 16 upward then downward
        for (int i = 0; i < 3; i++) begin res(32'h40, 32'd1, 32'd1, 3'd1, 1'b0); cyc(); end
        idle(); lookup(32'h40); cyc(); idle();
        chk("sat_up_lookup", {31'd0, pred_taken}, 1);
        for (int i = 0; i < 4; i++) begin res(32'h40, 32'd1, 32'd2, 3'd1, 1'b1); cyc(); end
        idle(); lookup(32'h40); cyc(); idle();
        chk("sat_down_lookup", {31'd0, pred_taken}, 0);

        // idx 16: 00 -> 01, then alias collision 01 -> 10 with old value returned
        res(32'h40, 32'd1, 32'd1, 3'd1, 1'b0); cyc();
        res(32'h40, 32'd1, 32'd1, 3'd1, 1'b0); lookup(32'h140); cyc(); idle();
        chk("raw_old_value", {31'd0, pred_taken}, 0);
        lookup(32'h140); cyc(); idle();
        chk("raw_new_value", {31'd0, pred_taken}, 1);

        cnt_clr = 1; cyc(); idle();
        chk("cnt_cleared", {16'd0, mispred_cnt}, 0);
        res(32'h100, 32'd5, 32'd5, 3'd2, 1'b1); cyc(); idle();
        chk("bne_mispredict", {31'd0, mispredict}, 1);
        chk("bne_cnt_one", {16'd0, mispred_cnt}, 1);
        res(32'h40, 32'd7, 32'd7, 3'd7, 1'b0); cyc(); idle();
        chk("rsvd_taken", {31'd0, res_taken}, 0);
        chk("rsvd_mispredict", {31'd0, mispredict}, 0);
        lookup(32'h40); cyc(); idle();
        chk("rsvd_bht_unchanged", {31'd0, pred_taken}, 1);

        cnt_clr = 1; cyc(); idle();
        for (int i = 0; i < 5; i++) begin res(32'h100, 32'd5, 32'd5, 3'd2, 1'b1); cyc(); end
        idle();
        chk("cnt2_saturated", {30'd0, mispred_cnt2}, 3);
        chk("cnt16_five", {16'd0, mispred_cnt}, 5);
        res(32'h100, 32'd5, 32'd5, 3'd2, 1'b1); cnt_clr = 1; cyc(); idle();
        chk("clr_priority", {16'd0, mispred_cnt}, 0);
        chk("clr_priority2", {30'd0, mispred_cnt2}, 0);

        for (int i = 0; i < 80; i++) begin
            pred_valid = 1'($urandom_range(0, 1));
            pred_pc = $urandom_range(0, 1) ? 32'h40 : 32'h140 + 32'($urandom_range(0, 3) * 4);
            res_valid = 1'($urandom_range(0, 1));
            res_pc = 32'h40 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 1) * 32'h100);
            rs_data = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            rt_data = $urandom_range(0, 1) ? rs_data : $urandom;
            Branch_type = 3'($urandom_range(0, 7));
            res_pred = 1'($urandom_range(0, 1));
            cnt_clr = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle();

        // Mid-stream reset drops results immediately and restores weak-not-taken
        res(32'h40, 32'd3, 32'd3, 3'd1, 1'b0); cyc();
        #2 rst_n = 0; #1;
        chk("async_reset_res_out_vld", {31'd0, res_out_vld}, 0);
        chk("async_reset_res_taken", {31'd0, res_taken}, 0);
        chk("async_reset_cnt", {16'd0, mispred_cnt}, 0);
        idle();
        @(negedge clk); rst_n = 1;
        lookup(32'h40); cyc(); idle();
        chk("reset_bht_lookup", {31'd0, pred_taken}, 0);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded bound");
        $fatal(1);
    end
endmodule
